// File: rtl/core_sequencer_if.sv
// Job/config and core-control bundle between a host and core_sequencer.
// Build option SEQ_PERF_EN adds the perf_cycles/perf_stalls counters to the bundle.
interface core_sequencer_if #(
  parameter int NIJ_W = 5,
  parameter int KIJ_W = 4
);
  logic             start;
  logic             cfg_mode;
  logic             cfg_relu;
  logic [1:0]       cfg_tile;
  logic [NIJ_W-1:0] cfg_nij;
  logic [KIJ_W-1:0] cfg_kij;
  logic [10:0]      cfg_wbase;
  logic [10:0]      cfg_xbase;
  logic [10:0]      cfg_pbase;
  logic             ofifo_valid;
  logic [33:0]      inst;
  logic             mode;
  logic             sel;
  logic [1:0]       tile;
  logic             relu;
  logic             busy;
  logic             done;
`ifdef SEQ_PERF_EN
  logic [31:0]      perf_cycles;
  logic [15:0]      perf_stalls;

  modport master (
    output start, cfg_mode, cfg_relu, cfg_tile, cfg_nij, cfg_kij,
    output cfg_wbase, cfg_xbase, cfg_pbase, ofifo_valid,
    input  inst, mode, sel, tile, relu, busy, done, perf_cycles, perf_stalls
  );
  modport slave (
    input  start, cfg_mode, cfg_relu, cfg_tile, cfg_nij, cfg_kij,
    input  cfg_wbase, cfg_xbase, cfg_pbase, ofifo_valid,
    output inst, mode, sel, tile, relu, busy, done, perf_cycles, perf_stalls
  );
`else
  modport master (
    output start, cfg_mode, cfg_relu, cfg_tile, cfg_nij, cfg_kij,
    output cfg_wbase, cfg_xbase, cfg_pbase, ofifo_valid,
    input  inst, mode, sel, tile, relu, busy, done
  );
  modport slave (
    input  start, cfg_mode, cfg_relu, cfg_tile, cfg_nij, cfg_kij,
    input  cfg_wbase, cfg_xbase, cfg_pbase, ofifo_valid,
    output inst, mode, sel, tile, relu, busy, done
  );
`endif
endinterface

// File: rtl/core_sequencer.sv
// Per-job instruction sequencer: WLD -> WPUSH -> XLD -> EXEC -> DRAIN per kij, psum banks ping-pong.
// Build option SEQ_PERF_EN adds busy-cycle and drain-stall counters.
module core_sequencer #(
  parameter int ROW   = 2,
  parameter int COL   = 2,
  parameter int NIJ_W = 5,
  parameter int KIJ_W = 4
) (
  input logic             clk,
  input logic             reset,
  core_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2((1 << NIJ_W) + ROW + COL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WLD_LAST  = CNT_W'(ROW);
  localparam logic [CNT_W-1:0] PUSH_LAST = CNT_W'(ROW + COL - 1);
  localparam logic [CNT_W-1:0] SKEW      = CNT_W'(ROW + COL - 1);
  localparam logic [10:0]      ROW_A     = 11'(ROW);
  localparam logic [NIJ_W-1:0] N_ONE     = NIJ_W'(1);
  localparam logic [KIJ_W-1:0] K_ONE     = KIJ_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WLD, S_WPUSH, S_XLD, S_EXEC, S_DRAIN, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NIJ_W-1:0] wr_q, wr_d;
  logic [KIJ_W-1:0] kij_q, kij_d;
  logic [NIJ_W-1:0] n_q;
  logic [KIJ_W-1:0] k_q;
  logic [10:0]      wbase_q, xbase_q, pbase_q;
  logic             mode_q, relu_cfg_q;
  logic [1:0]       tile_q;
  logic [33:0]      inst_q, inst_d;
  logic             sel_q, sel_d, relu_q, relu_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] n_ext;
  logic             last_kij, take_start, active;

  logic        acc, cen_p, wen_p, cen_x, ofifo_rd, l0_rd, l0_wr, exec_en, load_en;
  logic [10:0] a_p, a_x;

  assign n_ext      = CNT_W'(n_q);
  assign last_kij   = (kij_q == k_q - K_ONE);
  assign take_start = (state_q == S_IDLE) && bus.start;
  assign active     = state_q inside {S_WLD, S_WPUSH, S_XLD, S_EXEC, S_DRAIN};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      kij_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      kij_q   <= kij_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q        <= '0;
      k_q        <= '0;
      wbase_q    <= '0;
      xbase_q    <= '0;
      pbase_q    <= '0;
      mode_q     <= 1'b0;
      relu_cfg_q <= 1'b0;
      tile_q     <= '0;
    end else if (take_start) begin
      n_q        <= bus.cfg_nij;
      k_q        <= bus.cfg_kij;
      wbase_q    <= bus.cfg_wbase;
      xbase_q    <= bus.cfg_xbase;
      pbase_q    <= bus.cfg_pbase;
      mode_q     <= bus.cfg_mode;
      relu_cfg_q <= bus.cfg_relu;
      tile_q     <= bus.cfg_tile;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    wr_d    = wr_q;
    kij_d   = kij_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = S_WLD;
          kij_d   = '0;
          wr_d    = '0;
        end
      end
      S_WLD:   if (cnt_q == WLD_LAST)     begin state_d = S_WPUSH; cnt_d = '0; end
      S_WPUSH: if (cnt_q == PUSH_LAST)    begin state_d = S_XLD;   cnt_d = '0; end
      S_XLD:   if (cnt_q == n_ext)        begin state_d = S_EXEC;  cnt_d = '0; end
      S_EXEC:  if (cnt_q == n_ext + SKEW) begin state_d = S_DRAIN; cnt_d = '0; end
      S_DRAIN: begin
        cnt_d = '0;
        if (bus.ofifo_valid) begin
          wr_d = wr_q + N_ONE;
          if (wr_q == n_q - N_ONE) begin
            wr_d = '0;
            if (last_kij) begin
              state_d = S_FIN;
            end else begin
              state_d = S_WLD;
              kij_d   = kij_q + K_ONE;
            end
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from the current state and registered, so the inst stream trails the FSM by one cycle.
  always_comb begin
    acc      = 1'b0;
    cen_p    = 1'b1;
    wen_p    = 1'b1;
    a_p      = '0;
    cen_x    = 1'b1;
    a_x      = '0;
    ofifo_rd = 1'b0;
    l0_rd    = 1'b0;
    l0_wr    = 1'b0;
    exec_en  = 1'b0;
    load_en  = 1'b0;
    relu_d   = 1'b0;
    busy_d   = active;
    done_d   = (state_q == S_FIN);
    sel_d    = active ? kij_q[0] : sel_q;
    unique case (state_q)
      S_WLD: begin
        if (cnt_q != WLD_LAST) begin
          cen_x = 1'b0;
          a_x   = wbase_q + 11'(kij_q) * ROW_A + 11'(cnt_q);
        end
        l0_wr = (cnt_q != '0);
      end
      S_WPUSH: begin
        l0_rd   = 1'b1;
        load_en = 1'b1;
      end
      S_XLD: begin
        if (cnt_q != n_ext) begin
          cen_x = 1'b0;
          a_x   = xbase_q + 11'(cnt_q);
        end
        l0_wr = (cnt_q != '0);
      end
      S_EXEC: begin
        l0_rd   = 1'b1;
        exec_en = 1'b1;
      end
      S_DRAIN: begin
        acc    = (kij_q != '0);
        relu_d = relu_cfg_q && last_kij;
        if (bus.ofifo_valid) begin
          ofifo_rd = 1'b1;
          cen_p    = 1'b0;
          wen_p    = 1'b0;
          a_p      = pbase_q + 11'(wr_q);
        end
      end
      default: ;
    endcase
    inst_d = {acc, cen_p, wen_p, a_p, cen_x, 1'b1, a_x, ofifo_rd, 2'b00,
              l0_rd, l0_wr, exec_en, load_en};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q <= {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 18'd0};
      sel_q  <= 1'b0;
      relu_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      inst_q <= inst_d;
      sel_q  <= sel_d;
      relu_q <= relu_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.inst = inst_q;
  assign bus.mode = mode_q;
  assign bus.sel  = sel_q;
  assign bus.tile = tile_q;
  assign bus.relu = relu_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef SEQ_PERF_EN
  logic [31:0] perf_cyc_q;
  logic [15:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset || take_start) begin
      perf_cyc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (active) perf_cyc_q <= perf_cyc_q + 32'd1;
      if (state_q == S_DRAIN && !bus.ofifo_valid) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign bus.perf_cycles = perf_cyc_q;
  assign bus.perf_stalls = perf_stall_q;
`endif
endmodule
